// File: rtl/shift_led_ctrl.sv
// shift_led_ctrl: button-driven LED shift register with per-button
// synchroniser, debouncer and hold-to-repeat, plus four run-time modes
// (shift-with-fill, rotate, parallel load, freeze).
module shift_led_ctrl #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left_btn,
  input  logic             right_btn,
  input  logic             fill_left,
  input  logic             fill_right,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] values,
  output logic             left_evt,
  output logic             right_evt,
  output logic [15:0]      event_count
);

  // Counter compare points; counters are 32 bits so any legal parameter fits.
  localparam logic [31:0] DEB_LAST    = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] DELAY_LAST  = (REPEAT_DELAY > 0) ? 32'(REPEAT_DELAY - 1) : 32'd0;
  localparam logic [31:0] PERIOD_LAST = 32'(REPEAT_PERIOD - 1);
  localparam bit          REPEAT_EN   = (REPEAT_DELAY != 0);

  localparam logic [1:0] MODE_SHIFT  = 2'b00;
  localparam logic [1:0] MODE_ROTATE = 2'b01;
  localparam logic [1:0] MODE_LOAD   = 2'b10;

  // Index 0 is the left button, index 1 the right button.
  logic [1:0] btn;
  logic [1:0] evt;

  assign btn = {right_btn, left_btn};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic        sync1_reg;
      logic        sync2_reg;
      logic        deb_reg;
      logic [31:0] deb_cnt_reg;
      logic [31:0] rep_cnt_reg;
      logic        rep_phase_reg;
      logic        evt_reg;
      logic        accept;
      logic        deb_next;
      logic        press;
      logic        repeat_hit;

      // Debounce acceptance, press detection and repeat-pulse decision.
      // deb_next is used for repeat so the edge on which d falls never repeats.
      always_comb begin
        accept     = (sync2_reg != deb_reg) && (deb_cnt_reg == DEB_LAST);
        deb_next   = accept ? sync2_reg : deb_reg;
        press      = accept && sync2_reg;
        repeat_hit = REPEAT_EN && !press && deb_next &&
                     (rep_cnt_reg == (rep_phase_reg ? PERIOD_LAST : DELAY_LAST));
      end

      // Synchroniser, debouncer, repeat timer and registered event pulse.
      always_ff @(posedge clk) begin
        if (!reset) begin
          sync1_reg     <= 1'b0;
          sync2_reg     <= 1'b0;
          deb_reg       <= 1'b0;
          deb_cnt_reg   <= '0;
          rep_cnt_reg   <= '0;
          rep_phase_reg <= 1'b0;
          evt_reg       <= 1'b0;
        end else begin
          sync1_reg <= btn[gi];
          sync2_reg <= sync1_reg;
          deb_reg   <= deb_next;
          if ((sync2_reg == deb_reg) || accept) begin
            deb_cnt_reg <= '0;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + 32'd1;
          end
          evt_reg <= press || repeat_hit;
          // Repeat timer restarts on a press, idles while released, and
          // switches from the initial delay to the period after first repeat.
          if (press || !deb_next || !REPEAT_EN) begin
            rep_cnt_reg   <= '0;
            rep_phase_reg <= 1'b0;
          end else if (repeat_hit) begin
            rep_cnt_reg   <= '0;
            rep_phase_reg <= 1'b1;
          end else begin
            rep_cnt_reg <= rep_cnt_reg + 32'd1;
          end
        end
      end

      assign evt[gi] = evt_reg;
    end
  endgenerate

  logic [WIDTH-1:0] values_reg;
  logic [WIDTH-1:0] values_next;
  logic [15:0]      count_reg;
  logic [15:0]      count_next;

  // Apply a single pending event using the mode seen on this edge;
  // simultaneous left/right events cancel, freeze mode ignores events.
  always_comb begin
    values_next = values_reg;
    count_next  = count_reg;
    if ((evt[0] ^ evt[1]) && (mode != 2'b11)) begin
      count_next = count_reg + 16'd1;
      case (mode)
        MODE_SHIFT:  values_next = evt[0] ? {values_reg[WIDTH-2:0], fill_left}
                                          : {fill_right, values_reg[WIDTH-1:1]};
        MODE_ROTATE: values_next = evt[0] ? {values_reg[WIDTH-2:0], values_reg[WIDTH-1]}
                                          : {values_reg[0], values_reg[WIDTH-1:1]};
        MODE_LOAD:   values_next = load_value;
        default:     values_next = values_reg;
      endcase
    end
  end

  // LED register and event counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      values_reg <= '0;
      count_reg  <= '0;
    end else begin
      values_reg <= values_next;
      count_reg  <= count_next;
    end
  end

  assign values      = values_reg;
  assign event_count = count_reg;
  assign left_evt    = evt[0];
  assign right_evt   = evt[1];

endmodule

// File: tb/tb_shift_led_ctrl.sv
// Directed bench for shift_led_ctrl: table of single-press vectors plus
// hand sequences for glitch rejection, auto-repeat and reset mid-repeat.
module tb_shift_led_ctrl;

  logic        clk;
  logic        reset;
  logic        left_btn;
  logic        right_btn;
  logic        fill_left;
  logic        fill_right;
  logic [1:0]  mode;
  logic [7:0]  load_value;
  logic [7:0]  values;
  logic        left_evt;
  logic        right_evt;
  logic [15:0] event_count;

  shift_led_ctrl #(
    .WIDTH(8),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .left_btn(left_btn),
    .right_btn(right_btn),
    .fill_left(fill_left),
    .fill_right(fill_right),
    .mode(mode),
    .load_value(load_value),
    .values(values),
    .left_evt(left_evt),
    .right_evt(right_evt),
    .event_count(event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // side: 0 left, 1 right, 2 both in the same cycle
  typedef struct {
    int          side;
    logic [1:0]  md;
    logic        fl;
    logic        fr;
    logic [7:0]  ld;
    logic [7:0]  exp_val;
    logic [15:0] exp_cnt;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs[NVEC];

  int n_vec = 0;
  int miscompares = 0;
  int rep_exp[7] = '{6, 16, 21, 26, 31, 36, 41};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One press of 6 cycles: pulse expected at edge 6, update visible after edge 7.
  task automatic apply_vec(input int idx, input vec_t v);
    int nl, nr, kl, kr;
    logic [7:0]  got_v;
    logic [15:0] got_c;
    nl = 0; nr = 0; kl = 0; kr = 0;
    got_v = '0; got_c = '0;
    mode       = v.md;
    fill_left  = v.fl;
    fill_right = v.fr;
    load_value = v.ld;
    left_btn   = (v.side != 1);
    right_btn  = (v.side != 0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (left_evt) begin nl++; if (kl == 0) kl = k; end
      if (right_evt) begin nr++; if (kr == 0) kr = k; end
      if (k == 6) begin left_btn = 1'b0; right_btn = 1'b0; end
      if (k == 7) begin got_v = values; got_c = event_count; end
    end
    $display("vec %0d side=%0d mode=%0b values=%02h count=%0d lpulses=%0d rpulses=%0d",
             idx, v.side, v.md, got_v, got_c, nl, nr);
    check("left_pulses", 32'(nl), (v.side != 1) ? 32'd1 : 32'd0);
    check("right_pulses", 32'(nr), (v.side != 0) ? 32'd1 : 32'd0);
    if (v.side != 1) check("left_latency", 32'(kl), 32'd6);
    if (v.side != 0) check("right_latency", 32'(kr), 32'd6);
    check("values_at_edge7", 32'(got_v), 32'(v.exp_val));
    check("count_at_edge7", 32'(got_c), 32'(v.exp_cnt));
    check("values_settled", 32'(values), 32'(v.exp_val));
  endtask

  // Short high pulse on left_btn; must never produce an event.
  task automatic glitch(input int len, input logic [7:0] exp_v, input logic [15:0] exp_c);
    int n;
    n = 0;
    left_btn = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == len) left_btn = 1'b0;
      if (left_evt) n++;
    end
    $display("glitch len=%0d pulses=%0d values=%02h count=%0d", len, n, values, event_count);
    check("glitch_pulses", 32'(n), 32'd0);
    check("glitch_values", 32'(values), 32'(exp_v));
    check("glitch_count", 32'(event_count), 32'(exp_c));
  endtask

  initial begin
    int n;
    int edges[8];
    int first_k;
    logic [7:0]  v7;
    logic [15:0] c7;

    vecs[0]  = '{0, 2'b00, 1'b1, 1'b0, 8'h00, 8'h01, 16'd1};
    vecs[1]  = '{1, 2'b10, 1'b0, 1'b0, 8'h81, 8'h81, 16'd2};
    vecs[2]  = '{1, 2'b00, 1'b0, 1'b0, 8'h00, 8'h40, 16'd3};
    vecs[3]  = '{1, 2'b01, 1'b0, 1'b0, 8'h00, 8'h20, 16'd4};
    vecs[4]  = '{0, 2'b10, 1'b0, 1'b0, 8'h01, 8'h01, 16'd5};
    vecs[5]  = '{1, 2'b01, 1'b0, 1'b0, 8'h00, 8'h80, 16'd6};
    vecs[6]  = '{0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 16'd7};
    vecs[7]  = '{1, 2'b00, 1'b0, 1'b1, 8'h00, 8'h80, 16'd8};
    vecs[8]  = '{0, 2'b01, 1'b0, 1'b0, 8'h00, 8'h01, 16'd9};
    vecs[9]  = '{1, 2'b10, 1'b0, 1'b0, 8'hA5, 8'hA5, 16'd10};
    for (int i = 10; i < 16; i++) vecs[i] = '{0, 2'b11, 1'b1, 1'b1, 8'h00, 8'hA5, 16'd10};
    vecs[16] = '{0, 2'b10, 1'b0, 1'b0, 8'hA5, 8'hA5, 16'd11};
    vecs[17] = '{2, 2'b00, 1'b1, 1'b1, 8'h00, 8'hA5, 16'd11};
    vecs[18] = '{0, 2'b01, 1'b0, 1'b0, 8'h00, 8'h4B, 16'd12};
    vecs[19] = '{0, 2'b10, 1'b0, 1'b0, 8'h01, 8'h01, 16'd13};

    reset = 1'b0; left_btn = 1'b0; right_btn = 1'b0;
    fill_left = 1'b0; fill_right = 1'b0; mode = 2'b00; load_value = 8'h00;
    for (int k = 0; k < 3; k++) tick();
    $display("reset values=%02h count=%0d evt=%b%b", values, event_count, left_evt, right_evt);
    check("reset_values", 32'(values), 32'd0);
    check("reset_count", 32'(event_count), 32'd0);
    check("reset_left_evt", 32'(left_evt), 32'd0);
    check("reset_right_evt", 32'(right_evt), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) apply_vec(i, vecs[i]);

    glitch(3, 8'h01, 16'd13);
    glitch(1, 8'h01, 16'd13);

    // Held left in rotate mode: press plus six repeats, 0x01 -> 0x80.
    mode = 2'b01;
    n = 0;
    for (int i = 0; i < 8; i++) edges[i] = 0;
    left_btn = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      tick();
      if (left_evt) begin
        if (n < 8) edges[n] = k;
        n++;
      end
      if (k == 40) left_btn = 1'b0;
    end
    $display("repeat pulses=%0d values=%02h count=%0d", n, values, event_count);
    check("repeat_pulses", 32'(n), 32'd7);
    for (int i = 0; i < 7; i++) check("repeat_edge", 32'(edges[i]), 32'(rep_exp[i]));
    check("repeat_values", 32'(values), 32'h80);
    check("repeat_count", 32'(event_count), 32'd20);

    // Reset while repeating with the button still held, then a fresh press.
    mode = 2'b00; fill_left = 1'b1;
    left_btn = 1'b1;
    for (int k = 1; k <= 18; k++) tick();
    reset = 1'b0;
    tick();
    $display("midreset values=%02h count=%0d evt=%b%b", values, event_count, left_evt, right_evt);
    check("midreset_values", 32'(values), 32'd0);
    check("midreset_count", 32'(event_count), 32'd0);
    check("midreset_left_evt", 32'(left_evt), 32'd0);
    tick();
    check("midreset_left_evt2", 32'(left_evt), 32'd0);
    reset = 1'b1;
    n = 0; first_k = 0; v7 = '0; c7 = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (left_evt) begin n++; if (first_k == 0) first_k = k; end
      if (k == 7) begin v7 = values; c7 = event_count; end
      if (k == 8) left_btn = 1'b0;
    end
    $display("postreset first_pulse=%0d pulses=%0d values=%02h count=%0d", first_k, n, v7, c7);
    check("postreset_latency", 32'(first_k), 32'd6);
    check("postreset_pulses", 32'(n), 32'd1);
    check("postreset_values", 32'(v7), 32'h01);
    check("postreset_count", 32'(c7), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_led_ctrl.md
# shift_led_ctrl

Parametrised, button-driven serial shift register for the board LED bank. It generalises the earlier fixed 8-bit shifter:
- configurable width;
- on-chip debouncing of both direction buttons;
- hold-to-repeat auto-shifting;
- four run-time modes: shift-with-fill, rotate, parallel load, freeze.

It sits between the raw KEY/SW pins and the LED outputs.

## Interface
- WIDTH, 8, register/LED width; legal range 2..32
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples required to accept a button level change; minimum 1
- REPEAT_DELAY, 25000000, cycles from press pulse to first repeat pulse while held; 0 disables auto-repeat
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses; minimum 1
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-low (KEY0)
- left_btn  in  1  asynchronous, active-high "pressed" level
- right_btn  in  1  asynchronous, active-high "pressed" level
- fill_left  in  1  bit shifted into bit 0 on a left event (mode 00)
- fill_right  in  1  bit shifted into bit WIDTH-1 on a right event (mode 00)
- mode  in  2  00 shift-fill, 01 rotate, 10 load, 11 freeze
- load_value  in  WIDTH  word loaded in mode 10
- values  out  WIDTH  register contents, drives LEDs
- left_evt  out  1  one-cycle pulse per accepted left event (press or repeat)
- right_evt  out  1  one-cycle pulse per accepted right event
- event_count  out  16  number of register-changing events applied; wraps 0xFFFF -> 0

## Operation
- Each button passes through:
  - a 2-flop synchroniser, giving s;
  - a debouncer with debounced level d and counter c.
- Debouncer rules:
  - If s == d, then c <= 0.
  - Otherwise c increments.
  - When s != d and c == DEBOUNCE_CYCLES-1: d <= s and c <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES samples never changes d.
- Press event: registered pulse, asserted in the cycle d goes 0 -> 1. Releases (d 1 -> 0) generate nothing.
- Auto-repeat, per button, only when REPEAT_DELAY != 0:
  - The repeat counter clears on the press pulse and counts each cycle while d == 1.
  - Repeat pulses occur REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles.
  - d falling stops repeats immediately and clears the counter.
- left_evt/right_evt = press pulse OR repeat pulse for that button.
- Event application, next clock edge after the pulse, using mode sampled on that edge:
  - 00, left: values <= {values[WIDTH-2:0], fill_left}
  - 00, right: values <= {fill_right, values[WIDTH-1:1]}
  - 01, left: rotate left, values[WIDTH-1] -> bit 0
  - 01, right: rotate right, bit 0 -> values[WIDTH-1]
  - 10, either event: values <= load_value
  - 11: values unchanged; event_count unchanged; left_evt/right_evt still pulse
- event_count increments by 1 for every applied event in modes 00/01/10, even if values is numerically unchanged.
- Simultaneous left_evt and right_evt in the same cycle:
  - no change to values or event_count;
  - both pulses still visible.
- Mode change while a button is held takes effect on the next event; it does not restart repeat timing.

## Timing
- Reset (reset == 0 at a clock edge) clears:
  - values, event_count, left_evt, right_evt to 0;
  - synchronisers, d, c and repeat counters to 0.
- Reset asserted mid-debounce or mid-repeat aborts with no pulse.
- A button held through reset release is treated as a new press: pulse after full debounce.
- Latency, input rise to values update:
  - button sampled at edge 1, s valid after edge 2;
  - d and press pulse at edge 2+DEBOUNCE_CYCLES;
  - values and event_count updated at edge 3+DEBOUNCE_CYCLES.
- Repeat pulse k (k ≥ 1) at REPEAT_DELAY + (k-1)*REPEAT_PERIOD cycles after the press pulse; values update one edge later.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Bench parameters: WIDTH=8, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5 unless noted.

1. Reset, mode 00, fill_left=1, left_btn held 20 cycles from edge 1 -> left_evt at edge 6; values 0x00 -> 0x01 at edge 7; event_count=1.
2. Mode 00, values=0x81, fill_right=0, right press -> 0x40; then mode 01, right press -> 0x20; from 0x01, right rotate -> 0x80.
3. left_btn 3-cycle glitch, then 1-cycle glitch -> no left_evt; values and event_count unchanged.
4. Mode 01, values=0x01, left_btn held 40 cycles:
   - press pulse at cycle P, repeats at P+10, P+15, P+20, P+25, P+30, P+35;
   - values ends 0x80;
   - event_count=7.
5. Mode 10, load_value=0xA5, right press -> values=0xA5; mode 11, six left presses -> values stays 0xA5, six left_evt pulses, event_count unchanged.
6. Both buttons rising the same cycle -> both evt pulses, values unchanged. reset=0 mid-repeat -> all outputs 0. Button still held after reset release -> new press after 4+2 cycles.
